// File: rtl/ps_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps_ctrl
//  Description : Power-spectrum datapath sequencer. Frames handshaked samples
//                into windows, strobes the active-low datapath enable per
//                sample, captures the window result and flags threshold hits.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps_ctrl #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 40,
    parameter int WIN_LEN      = 50,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [OUTPUT_WIDTH-1:0] thresh,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [INPUT_WIDTH-1:0]  s_data,
    output logic [INPUT_WIDTH-1:0]  ps_din,
    output logic                    ps_en,
    output logic                    ps_rst,
    input  logic [OUTPUT_WIDTH-1:0] ps_dout,
    input  logic                    ps_data_valid,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [OUTPUT_WIDTH-1:0] r_data,
    output logic                    r_detect,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int c_CNT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST_SAMPLE = c_CNT_W'(WIN_LEN - 1);
    localparam logic [c_WAIT_W-1:0] c_LAST_WAIT   = c_WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_WAIT_W-1:0]     r_wait_cnt;
    logic [OUTPUT_WIDTH-1:0] r_thresh;
    logic                    r_s_ready;
    logic                    r_ps_en;
    logic                    r_ps_rst;
    logic [INPUT_WIDTH-1:0]  r_ps_din;
    logic                    r_res_valid;
    logic [OUTPUT_WIDTH-1:0] r_res_data;
    logic                    r_res_detect;
    logic                    r_overrun;
    logic                    r_timeout_err;

    state_t                  w_state;
    logic [c_CNT_W-1:0]      w_cnt;
    logic [c_WAIT_W-1:0]     w_wait_cnt;
    logic [OUTPUT_WIDTH-1:0] w_thresh;
    logic                    w_s_ready;
    logic                    w_ps_en;
    logic                    w_ps_rst;
    logic [INPUT_WIDTH-1:0]  w_ps_din;
    logic                    w_res_valid;
    logic [OUTPUT_WIDTH-1:0] w_res_data;
    logic                    w_res_detect;
    logic                    w_overrun;
    logic                    w_timeout_err;
    logic                    w_accept;
    logic                    w_load;

    assign w_accept = r_s_ready && s_valid;

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_wait_cnt    = r_wait_cnt;
        w_thresh      = r_thresh;
        w_s_ready     = r_s_ready;
        w_ps_en       = 1'b1;
        w_ps_rst      = r_ps_rst;
        w_ps_din      = r_ps_din;
        w_res_valid   = r_res_valid;
        w_res_data    = r_res_data;
        w_res_detect  = r_res_detect;
        w_overrun     = r_overrun;
        w_timeout_err = r_timeout_err;
        w_load        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_s_ready = 1'b0;
                w_ps_rst  = 1'b1;
                if (start) begin
                    w_state       = ST_RUN;
                    w_thresh      = thresh;
                    w_cnt         = '0;
                    w_ps_rst      = 1'b0;
                    w_s_ready     = 1'b1;
                    w_overrun     = 1'b0;
                    w_timeout_err = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state    = ST_IDLE;
                    w_ps_rst   = 1'b1;
                    w_s_ready  = 1'b0;
                    w_cnt      = '0;
                    w_wait_cnt = '0;
                end else if (w_accept) begin
                    w_ps_din = s_data;
                    w_ps_en  = 1'b0;
                    if (r_cnt == c_LAST_SAMPLE) begin
                        w_cnt      = '0;
                        w_wait_cnt = '0;
                        w_state    = ST_WAIT;
                        w_s_ready  = 1'b0;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A stop abandons the window even if its result arrives this cycle.
                if (stop) begin
                    w_state    = ST_IDLE;
                    w_ps_rst   = 1'b1;
                    w_s_ready  = 1'b0;
                    w_cnt      = '0;
                    w_wait_cnt = '0;
                end else if (ps_data_valid) begin
                    w_load    = 1'b1;
                    w_state   = ST_RUN;
                    w_s_ready = 1'b1;
                end else if (r_wait_cnt == c_LAST_WAIT) begin
                    w_timeout_err = 1'b1;
                    w_state       = ST_RUN;
                    w_s_ready     = 1'b1;
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state   = ST_IDLE;
                w_s_ready = 1'b0;
                w_ps_rst  = 1'b1;
            end
        endcase

        // A load always wins over a same-cycle consume so the newest result stays visible.
        if (w_load) begin
            w_res_valid  = 1'b1;
            w_res_data   = ps_dout;
            w_res_detect = $signed(ps_dout) > $signed(r_thresh);
            if (r_res_valid && !r_ready) begin
                w_overrun = 1'b1;
            end
        end else if (r_res_valid && r_ready) begin
            w_res_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_wait_cnt    <= '0;
            r_thresh      <= '0;
            r_s_ready     <= 1'b0;
            r_ps_en       <= 1'b1;
            r_ps_rst      <= 1'b1;
            r_ps_din      <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_detect  <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_wait_cnt    <= w_wait_cnt;
            r_thresh      <= w_thresh;
            r_s_ready     <= w_s_ready;
            r_ps_en       <= w_ps_en;
            r_ps_rst      <= w_ps_rst;
            r_ps_din      <= w_ps_din;
            r_res_valid   <= w_res_valid;
            r_res_data    <= w_res_data;
            r_res_detect  <= w_res_detect;
            r_overrun     <= w_overrun;
            r_timeout_err <= w_timeout_err;
        end
    end

    assign s_ready     = r_s_ready;
    assign ps_din      = r_ps_din;
    assign ps_en       = r_ps_en;
    assign ps_rst      = r_ps_rst;
    assign r_valid     = r_res_valid;
    assign r_data      = r_res_data;
    assign r_detect    = r_res_detect;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ps_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps_ctrl
//  Description : Directed self-checking bench for ps_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [39:0] thresh;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [15:0] ps_din;
    logic        ps_en;
    logic        ps_rst;
    logic [39:0] ps_dout;
    logic        ps_data_valid;
    logic        r_valid;
    logic        r_ready;
    logic [39:0] r_data;
    logic        r_detect;
    logic        overrun;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;
    int pulses2;

    always #5 clk = ~clk;

    ps_ctrl #(
        .INPUT_WIDTH (16),
        .OUTPUT_WIDTH(40),
        .WIN_LEN     (50),
        .TIMEOUT     (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .thresh       (thresh),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .ps_din       (ps_din),
        .ps_en        (ps_en),
        .ps_rst       (ps_rst),
        .ps_dout      (ps_dout),
        .ps_data_valid(ps_data_valid),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_data       (r_data),
        .r_detect     (r_detect),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check40(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Streams n back-to-back samples and counts enable strobes seen.
    task automatic send_samples(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i * 7 - 100);
            @(negedge clk);
            if (ps_en == 1'b0) cnt++;
        end
        s_valid = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [39:0] v);
        repeat (dly - 1) @(negedge clk);
        ps_data_valid = 1'b1;
        ps_dout       = v;
        @(negedge clk);
        ps_data_valid = 1'b0;
    endtask

    task automatic do_start(input logic [39:0] th);
        start  = 1'b1;
        thresh = th;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic consume();
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; thresh = '0;
        s_valid = 1'b0; s_data = '0; ps_dout = '0; ps_data_valid = 1'b0; r_ready = 1'b0;

        // T1: reset
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_ps_en", ps_en, 1);
        check("rst_ps_rst", ps_rst, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        check40("rst_r_data", r_data, 40'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", s_ready, 0);

        // T2: one full window, positive result above threshold
        do_start(40'd500);
        check("start_s_ready", s_ready, 1);
        check("start_ps_rst", ps_rst, 0);
        send_samples(50, pulses);
        check("t2_pulses", pulses, 50);
        check("t2_s_ready_low", s_ready, 0);
        repeat (2) @(negedge clk);
        check("t2_ps_en_idle", ps_en, 1);
        check("t2_r_valid_pre", r_valid, 0);
        ps_data_valid = 1'b1;
        ps_dout       = 40'd1000;
        @(negedge clk);
        ps_data_valid = 1'b0;
        check("t2_r_valid", r_valid, 1);
        check40("t2_r_data", r_data, 40'd1000);
        check("t2_detect", r_detect, 1);
        check("t2_s_ready_back", s_ready, 1);
        consume();
        check("t2_consumed", r_valid, 0);

        // T3: signed threshold compare, start while running is ignored
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_ps_rst", ps_rst, 1);
        check("stop_s_ready", s_ready, 0);
        do_start(-40'sd10);
        do_start(40'd1000);
        check("start_ignored_ps_rst", ps_rst, 0);
        send_samples(50, pulses);
        respond(3, -40'sd20);
        check40("t3_r_data_neg", r_data, -40'sd20);
        check("t3_detect_neg", r_detect, 0);
        consume();
        send_samples(50, pulses);
        respond(3, -40'sd10);
        check("t3_detect_equal", r_detect, 0);
        consume();

        // T4: overrun with two unconsumed windows
        send_samples(50, pulses);
        respond(2, -40'sd9);
        check("t4_detect_above", r_detect, 1);
        check("t4_no_overrun", overrun, 0);
        send_samples(50, pulses);
        respond(2, -40'sd5);
        check("t4_overrun", overrun, 1);
        check40("t4_r_data", r_data, -40'sd5);
        check("t4_r_valid", r_valid, 1);

        // T5: missing datapath result times out
        send_samples(50, pulses);
        repeat (63) @(negedge clk);
        check("t5_timeout_early", timeout_err, 0);
        check("t5_s_ready_wait", s_ready, 0);
        @(negedge clk);
        check("t5_timeout", timeout_err, 1);
        check("t5_s_ready_back", s_ready, 1);
        check("t5_r_valid_kept", r_valid, 1);
        check40("t5_r_data_kept", r_data, -40'sd5);
        consume();
        check("t5_consumed", r_valid, 0);
        check("t5_overrun_sticky", overrun, 1);

        // T6: stop mid-window, restart needs a full window
        send_samples(20, pulses);
        stop    = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        stop    = 1'b0;
        s_valid = 1'b0;
        check("t6_stop_no_accept", ps_en, 1);
        check("t6_ps_rst", ps_rst, 1);
        check("t6_s_ready", s_ready, 0);
        do_start(40'd500);
        check("t6_flags_clr_ov", overrun, 0);
        check("t6_flags_clr_to", timeout_err, 0);
        ps_data_valid = 1'b1;
        ps_dout       = 40'd7;
        @(negedge clk);
        ps_data_valid = 1'b0;
        check("t6_dv_ignored", r_valid, 0);
        send_samples(49, pulses);
        check("t6_49_s_ready", s_ready, 1);
        send_samples(1, pulses2);
        check("t6_50_s_ready", s_ready, 0);
        check("t6_pulses", pulses + pulses2, 50);
        respond(2, 40'd2000);
        check40("t6_r_data", r_data, 40'd2000);
        check("t6_detect", r_detect, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
